// File: rtl/swc_rtu_arb_pkg.sv
// Shared types and helpers for the RTU port arbiter: per-port and arbiter
// state encodings plus an index-width helper.
package swc_rtu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    HOLD
  } port_state_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_REQ
  } arb_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int idx_width(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/swc_rr_pick.sv
// Combinational round-robin picker: first eligible port at or after rr_ptr,
// wrapping modulo the port count.
module swc_rr_pick
  import swc_rtu_arb_pkg::*;
#(
  parameter int g_num_ports      = 8,
  parameter int g_port_idx_width = 3
) (
  input  logic [g_num_ports-1:0]      eligible,
  input  logic [g_port_idx_width-1:0] rr_ptr,
  output logic [g_port_idx_width-1:0] grant_idx,
  output logic                        found
);

  localparam int N    = g_num_ports;
  localparam int SumW = idx_width(g_num_ports) + 1;

  logic [2*N-1:0] rotated;
  logic [SumW-1:0] sum;
  int offset;

  // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit
  // is the offset of the winner from the pointer.
  always_comb begin
    rotated   = {eligible, eligible} >> rr_ptr;
    found     = 1'b0;
    offset    = 0;
    sum       = '0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = i;
      end
    end
    sum = SumW'(rr_ptr) + SumW'(offset);
    if (sum >= SumW'(N)) begin
      sum = sum - SumW'(N);
    end
    grant_idx = g_port_idx_width'(sum);
  end

endmodule

// File: rtl/swc_rtu_port_arbiter.sv
// Shares one RTU lookup engine among all switch ports and steers each
// response into a per-port holding register until swc_core acknowledges it.
module swc_rtu_port_arbiter
  import swc_rtu_arb_pkg::*;
#(
  parameter int g_num_ports      = 8,
  parameter int g_prio_width     = 3,
  parameter int g_port_idx_width = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [g_num_ports-1:0]               port_req_i,
  output logic [g_num_ports-1:0]               port_req_ack_o,
  output logic                                 rtu_req_valid_o,
  output logic [g_port_idx_width-1:0]          rtu_req_port_o,
  input  logic                                 rtu_req_ready_i,
  input  logic                                 rtu_rsp_valid_i,
  input  logic [g_port_idx_width-1:0]          rtu_rsp_port_i,
  input  logic [g_num_ports-1:0]               rtu_rsp_mask_i,
  input  logic                                 rtu_rsp_drop_i,
  input  logic [g_prio_width-1:0]              rtu_rsp_prio_i,
  output logic [g_num_ports-1:0]               rtu_rsp_valid_o,
  input  logic [g_num_ports-1:0]               rtu_rsp_ack_i,
  output logic [g_num_ports*g_num_ports-1:0]   rtu_dst_port_mask_o,
  output logic [g_num_ports-1:0]               rtu_drop_o,
  output logic [g_num_ports*g_prio_width-1:0]  rtu_prio_o,
  output logic                                 rsp_err_o
);

  localparam int N  = g_num_ports;
  localparam int PW = g_prio_width;
  localparam int IW = g_port_idx_width;

  arb_state_e arb_state, arb_state_nxt;
  logic [IW-1:0] req_port, req_port_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic grant;

  port_state_e port_state [N];
  port_state_e port_state_nxt [N];

  logic [N-1:0] eligible;
  logic [N-1:0] ack_vec;
  logic [N-1:0] rsp_hit;
  logic [IW-1:0] pick_idx;
  logic pick_found;

  // Only an idle port may request, which caps each port at one lookup in flight.
  always_comb begin
    eligible = '0;
    rsp_hit  = '0;
    ack_vec  = '0;
    for (int p = 0; p < N; p++) begin
      eligible[p] = (port_state[p] == IDLE) && port_req_i[p];
      rsp_hit[p]  = rtu_rsp_valid_i && (rtu_rsp_port_i == IW'(p))
                    && (port_state[p] == PENDING);
      ack_vec[p]  = grant && (req_port == IW'(p));
    end
  end

  swc_rr_pick #(
    .g_num_ports      (N),
    .g_port_idx_width (IW)
  ) u_rr_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant_idx (pick_idx),
    .found     (pick_found)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arb_state <= ARB_IDLE;
      req_port  <= '0;
      rr_ptr    <= '0;
    end else begin
      arb_state <= arb_state_nxt;
      req_port  <= req_port_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  // Once a port is latched into ARB_REQ the request is committed, even if the
  // port later withdraws its request level.
  always_comb begin
    arb_state_nxt = arb_state;
    req_port_nxt  = req_port;
    rr_ptr_nxt    = rr_ptr;
    grant         = 1'b0;
    unique case (arb_state)
      ARB_IDLE: begin
        if (pick_found) begin
          req_port_nxt  = pick_idx;
          arb_state_nxt = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (rtu_req_ready_i) begin
          grant         = 1'b1;
          rr_ptr_nxt    = (req_port == IW'(N - 1)) ? '0 : req_port + IW'(1);
          arb_state_nxt = ARB_IDLE;
        end
      end
      default: arb_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < N; p++) begin
      if (rst_i) begin
        port_state[p] <= IDLE;
      end else begin
        port_state[p] <= port_state_nxt[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < N; p++) begin
      port_state_nxt[p] = port_state[p];
      unique case (port_state[p])
        IDLE:    if (ack_vec[p])       port_state_nxt[p] = PENDING;
        PENDING: if (rsp_hit[p])       port_state_nxt[p] = HOLD;
        HOLD:    if (rtu_rsp_ack_i[p]) port_state_nxt[p] = IDLE;
        default: port_state_nxt[p] = IDLE;
      endcase
    end
  end

  // Held data survives the ack; only the valid bit (the HOLD state) clears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rtu_dst_port_mask_o <= '0;
      rtu_drop_o          <= '0;
      rtu_prio_o          <= '0;
      rsp_err_o           <= 1'b0;
    end else begin
      for (int p = 0; p < N; p++) begin
        if (rsp_hit[p]) begin
          rtu_dst_port_mask_o[p*N +: N] <= rtu_rsp_mask_i;
          rtu_drop_o[p]                 <= rtu_rsp_drop_i;
          rtu_prio_o[p*PW +: PW]        <= rtu_rsp_prio_i;
        end
      end
      rsp_err_o <= rtu_rsp_valid_i && (rsp_hit == '0);
    end
  end

  always_comb begin
    rtu_rsp_valid_o = '0;
    for (int p = 0; p < N; p++) begin
      rtu_rsp_valid_o[p] = (port_state[p] == HOLD);
    end
  end

  assign rtu_req_valid_o = (arb_state == ARB_REQ);
  assign rtu_req_port_o  = req_port;
  assign port_req_ack_o  = ack_vec;

endmodule

// File: tb/tb_swc_rtu_port_arbiter.sv
// Directed self-checking bench for swc_rtu_port_arbiter (N=8, 4-bit port index
// so that an out-of-range response port can be driven).
module tb_swc_rtu_port_arbiter;

  localparam int N  = 8;
  localparam int PW = 3;
  localparam int IW = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    port_req_i = '0;
  logic [N-1:0]    port_req_ack_o;
  logic            rtu_req_valid_o;
  logic [IW-1:0]   rtu_req_port_o;
  logic            rtu_req_ready_i = 1'b0;
  logic            rtu_rsp_valid_i = 1'b0;
  logic [IW-1:0]   rtu_rsp_port_i = '0;
  logic [N-1:0]    rtu_rsp_mask_i = '0;
  logic            rtu_rsp_drop_i = 1'b0;
  logic [PW-1:0]   rtu_rsp_prio_i = '0;
  logic [N-1:0]    rtu_rsp_valid_o;
  logic [N-1:0]    rtu_rsp_ack_i = '0;
  logic [N*N-1:0]  rtu_dst_port_mask_o;
  logic [N-1:0]    rtu_drop_o;
  logic [N*PW-1:0] rtu_prio_o;
  logic            rsp_err_o;

  int tests_run = 0;
  int tests_failed = 0;

  swc_rtu_port_arbiter #(
    .g_num_ports      (N),
    .g_prio_width     (PW),
    .g_port_idx_width (IW)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .port_req_i          (port_req_i),
    .port_req_ack_o      (port_req_ack_o),
    .rtu_req_valid_o     (rtu_req_valid_o),
    .rtu_req_port_o      (rtu_req_port_o),
    .rtu_req_ready_i     (rtu_req_ready_i),
    .rtu_rsp_valid_i     (rtu_rsp_valid_i),
    .rtu_rsp_port_i      (rtu_rsp_port_i),
    .rtu_rsp_mask_i      (rtu_rsp_mask_i),
    .rtu_rsp_drop_i      (rtu_rsp_drop_i),
    .rtu_rsp_prio_i      (rtu_rsp_prio_i),
    .rtu_rsp_valid_o     (rtu_rsp_valid_o),
    .rtu_rsp_ack_i       (rtu_rsp_ack_i),
    .rtu_dst_port_mask_o (rtu_dst_port_mask_o),
    .rtu_drop_o          (rtu_drop_o),
    .rtu_prio_o          (rtu_prio_o),
    .rsp_err_o           (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs are changed and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    port_req_i      = '0;
    rtu_req_ready_i = 1'b0;
    rtu_rsp_valid_i = 1'b0;
    rtu_rsp_port_i  = '0;
    rtu_rsp_mask_i  = '0;
    rtu_rsp_drop_i  = 1'b0;
    rtu_rsp_prio_i  = '0;
    rtu_rsp_ack_i   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic send_rsp(input int port, input logic [N-1:0] mask,
                          input logic drop, input logic [PW-1:0] prio);
    rtu_rsp_valid_i = 1'b1;
    rtu_rsp_port_i  = IW'(port);
    rtu_rsp_mask_i  = mask;
    rtu_rsp_drop_i  = drop;
    rtu_rsp_prio_i  = prio;
    tick();
    rtu_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({rtu_req_valid_o, rtu_req_port_o, port_req_ack_o, rtu_rsp_valid_o,
         rtu_drop_o, rsp_err_o} !== '0 || rtu_dst_port_mask_o !== '0 || rtu_prio_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: req_valid=%b port=%0d ack=%h rsp_valid=%h mask=%h drop=%h prio=%h err=%b, required all 0",
               rtu_req_valid_o, rtu_req_port_o, port_req_ack_o, rtu_rsp_valid_o,
               rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o, rsp_err_o);
    end
  endtask

  task automatic test_single_port();
    do_reset();
    port_req_i      = 8'h04;
    rtu_req_ready_i = 1'b1;
    tick();
    tests_run++;
    if (rtu_req_valid_o !== 1'b1 || rtu_req_port_o !== 4'd2 || port_req_ack_o !== 8'h04) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: valid=%b port=%0d ack=%h, required 1/2/04",
               rtu_req_valid_o, rtu_req_port_o, port_req_ack_o);
    end
    port_req_i = '0;
    tick();
    tests_run++;
    if (rtu_req_valid_o !== 1'b0 || port_req_ack_o !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL single_ack_pulse: valid=%b ack=%h, required 0/00",
               rtu_req_valid_o, port_req_ack_o);
    end
    send_rsp(2, 8'h81, 1'b0, 3'd5);
    tests_run++;
    if (rtu_rsp_valid_o !== 8'h04 || rtu_dst_port_mask_o[2*N +: N] !== 8'h81 ||
        rtu_prio_o[2*PW +: PW] !== 3'd5 || rtu_drop_o !== 8'h00 || rsp_err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_capture: rsp_valid=%h mask2=%h prio2=%0d drop=%h err=%b, required 04/81/5/00/0",
               rtu_rsp_valid_o, rtu_dst_port_mask_o[2*N +: N], rtu_prio_o[2*PW +: PW],
               rtu_drop_o, rsp_err_o);
    end
    rtu_rsp_ack_i = 8'h04;
    tick();
    rtu_rsp_ack_i = '0;
    tests_run++;
    if (rtu_rsp_valid_o !== 8'h00 || rtu_dst_port_mask_o[2*N +: N] !== 8'h81) begin
      tests_failed++;
      $display("[TB] FAIL single_ack_clear: rsp_valid=%h mask2=%h, required 00/81",
               rtu_rsp_valid_o, rtu_dst_port_mask_o[2*N +: N]);
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int gcyc[$];
    int last = -1;
    int cyc = 0;
    int errs = 0;
    do_reset();
    rtu_req_ready_i = 1'b1;
    port_req_i      = 8'hFF;
    while (grants.size() < 9 && cyc < 200) begin
      tick();
      cyc++;
      if (rsp_err_o) errs++;
      rtu_rsp_valid_i = 1'b0;
      rtu_rsp_ack_i   = rtu_rsp_valid_o;
      if (last >= 0) begin
        rtu_rsp_valid_i = 1'b1;
        rtu_rsp_port_i  = IW'(last);
        rtu_rsp_mask_i  = N'(1 << last);
        last = -1;
      end
      if (port_req_ack_o != '0) begin
        last = onehot_idx(port_req_ack_o);
        grants.push_back(last);
        gcyc.push_back(cyc);
      end
    end
    clear_inputs();
    tests_run++;
    if (grants.size() != 9) begin
      tests_failed++;
      $display("[TB] FAIL rr_grant_count: got %0d grants, required 9", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      tests_run++;
      if (grants[i] != (i % N)) begin
        tests_failed++;
        $display("[TB] FAIL rr_order[%0d]: granted %0d, required %0d", i, grants[i], i % N);
      end
    end
    for (int i = 1; i < gcyc.size(); i++) begin
      tests_run++;
      if (gcyc[i] - gcyc[i-1] != 2) begin
        tests_failed++;
        $display("[TB] FAIL rr_spacing[%0d]: %0d cycles between grants, required 2",
                 i, gcyc[i] - gcyc[i-1]);
      end
    end
    tests_run++;
    if (errs != 0) begin
      tests_failed++;
      $display("[TB] FAIL rr_no_err: %0d rsp_err pulses, required 0", errs);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    port_req_i = 8'h02;
    tick();
    port_req_i = '0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (rtu_req_valid_o !== 1'b1 || rtu_req_port_o !== 4'd1 || port_req_ack_o !== 8'h00) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold[%0d]: valid=%b port=%0d ack=%h, required 1/1/00",
                 i, rtu_req_valid_o, rtu_req_port_o, port_req_ack_o);
      end
      tick();
    end
    rtu_req_ready_i = 1'b1;
    #1;
    tests_run++;
    if (port_req_ack_o !== 8'h02) begin
      tests_failed++;
      $display("[TB] FAIL bp_ack_on_ready: ack=%h, required 02", port_req_ack_o);
    end
    tick();
    tests_run++;
    if (rtu_req_valid_o !== 1'b0 || port_req_ack_o !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL bp_after_grant: valid=%b ack=%h, required 0/00",
               rtu_req_valid_o, port_req_ack_o);
    end
  endtask

  task automatic test_one_outstanding();
    int cnt3 = 0;
    int cnt4 = 0;
    do_reset();
    rtu_req_ready_i = 1'b1;
    port_req_i      = 8'h08;
    tick();
    port_req_i = '0;
    tick();
    send_rsp(3, 8'hF0, 1'b0, 3'd1);
    tests_run++;
    if (rtu_rsp_valid_o !== 8'h08) begin
      tests_failed++;
      $display("[TB] FAIL hold_setup: rsp_valid=%h, required 08", rtu_rsp_valid_o);
    end
    port_req_i = 8'h18;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (port_req_ack_o[3]) cnt3++;
      if (port_req_ack_o[4]) cnt4++;
    end
    tests_run++;
    if (cnt3 != 0 || cnt4 != 1) begin
      tests_failed++;
      $display("[TB] FAIL hold_no_regrant: port3 grants=%0d port4 grants=%0d, required 0/1",
               cnt3, cnt4);
    end
    rtu_rsp_ack_i = 8'h08;
    tick();
    rtu_rsp_ack_i = '0;
    tests_run++;
    if (rtu_rsp_valid_o !== 8'h00 || rtu_req_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hold_ack: rsp_valid=%h req_valid=%b, required 00/0",
               rtu_rsp_valid_o, rtu_req_valid_o);
    end
    tick();
    tests_run++;
    if (rtu_req_valid_o !== 1'b1 || rtu_req_port_o !== 4'd3 || port_req_ack_o !== 8'h08) begin
      tests_failed++;
      $display("[TB] FAIL hold_regrant: valid=%b port=%0d ack=%h, required 1/3/08",
               rtu_req_valid_o, rtu_req_port_o, port_req_ack_o);
    end
    clear_inputs();
  endtask

  task automatic test_unexpected_rsp();
    int bad_ports[2] = '{5, 9};
    do_reset();
    rtu_req_ready_i = 1'b1;
    port_req_i      = 8'h04;
    tick();
    port_req_i = '0;
    tick();
    send_rsp(2, 8'h3C, 1'b1, 3'd6);
    tests_run++;
    if (rsp_err_o !== 1'b0 || rtu_rsp_valid_o !== 8'h04) begin
      tests_failed++;
      $display("[TB] FAIL unexp_setup: err=%b rsp_valid=%h, required 0/04", rsp_err_o, rtu_rsp_valid_o);
    end
    for (int k = 0; k < 2; k++) begin
      rtu_rsp_ack_i = 8'h20;
      send_rsp(bad_ports[k], 8'hFF, 1'b0, 3'd7);
      rtu_rsp_ack_i = '0;
      tests_run++;
      if (rsp_err_o !== 1'b1 || rtu_rsp_valid_o !== 8'h04 ||
          rtu_dst_port_mask_o !== 64'h0000_0000_003C_0000 ||
          rtu_drop_o !== 8'h04 || rtu_prio_o !== 24'h000180) begin
        tests_failed++;
        $display("[TB] FAIL unexp_port%0d: err=%b rsp_valid=%h mask=%h drop=%h prio=%h, required 1/04/00000000003c0000/04/000180",
                 bad_ports[k], rsp_err_o, rtu_rsp_valid_o, rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o);
      end
      tick();
      tests_run++;
      if (rsp_err_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL unexp_pulse_port%0d: err=%b one cycle later, required 0", bad_ports[k], rsp_err_o);
      end
    end
  endtask

  // Continues from the unexpected-response state: port 2 is held, rr_ptr is 3.
  task automatic test_reset_mid_op();
    rtu_req_ready_i = 1'b0;
    port_req_i      = 8'h02;
    tick();
    tests_run++;
    if (rtu_req_valid_o !== 1'b1 || rtu_rsp_valid_o !== 8'h04) begin
      tests_failed++;
      $display("[TB] FAIL midrst_setup: req_valid=%b rsp_valid=%h, required 1/04",
               rtu_req_valid_o, rtu_rsp_valid_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i      = 1'b0;
    port_req_i = '0;
    tests_run++;
    if ({rtu_req_valid_o, rtu_req_port_o, port_req_ack_o, rtu_rsp_valid_o,
         rtu_drop_o, rsp_err_o} !== '0 || rtu_dst_port_mask_o !== '0 || rtu_prio_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_clear: req_valid=%b port=%0d ack=%h rsp_valid=%h mask=%h drop=%h prio=%h err=%b, required all 0",
               rtu_req_valid_o, rtu_req_port_o, port_req_ack_o, rtu_rsp_valid_o,
               rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o, rsp_err_o);
    end
    port_req_i      = 8'h81;
    rtu_req_ready_i = 1'b1;
    tick();
    tests_run++;
    if (rtu_req_valid_o !== 1'b1 || rtu_req_port_o !== 4'd0 || port_req_ack_o !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL midrst_fresh_grant: valid=%b port=%0d ack=%h, required 1/0/01",
               rtu_req_valid_o, rtu_req_port_o, port_req_ack_o);
    end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_one_outstanding();
    test_unexpected_rsp();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
